// File: rtl/text_cell_writer.sv
// Character-cell text layer: COLS x ROWS char RAM written by put/cursor/clear
// commands, read by the beam position to produce a registered one-bit cell mask.
//
// state    | meaning
// ST_CLEAR | sweeping 8'h20 across every cell, one per cycle; commands refused
// ST_IDLE  | accepting one command per cycle
module text_cell_writer #(
   parameter int COLS  = 80,
   parameter int ROWS  = 10,
   parameter int SCALE = 4,
   localparam int CW = $clog2(COLS),
   localparam int RW = $clog2(ROWS),
   localparam int AW = $clog2(COLS*ROWS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [7:0]    cmd_char,
   input  logic [CW-1:0] cmd_col,
   input  logic [RW-1:0] cmd_row,
   output logic          cmd_err,
   output logic          busy,
   output logic [CW-1:0] cursor_col,
   output logic [RW-1:0] cursor_row,
   input  logic [9:0]    pixel_x,
   input  logic [9:0]    pixel_y,
   input  logic [9:0]    origin_x,
   input  logic [9:0]    origin_y,
   output logic          pix_on
);

   localparam int          CELLS   = COLS*ROWS;
   localparam logic [10:0] WIN_W   = 11'(COLS*SCALE);
   localparam logic [10:0] WIN_H   = 11'(ROWS*SCALE);
   localparam logic [10:0] SCALE_W = 11'(SCALE);
   localparam logic [1:0]  OP_PUT  = 2'b00;
   localparam logic [1:0]  OP_SET  = 2'b01;
   localparam logic [1:0]  OP_CLR  = 2'b10;

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   clr_addr_q, clr_addr_d;
   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   logic            cmd_err_q, cmd_err_d;
   logic            pix_on_q, pix_on_d;
   logic [7:0]      ram_q [CELLS];

   logic            cmd_accept;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [7:0]      wr_data;
   logic [AW-1:0]   cur_addr;

   assign cmd_ready  = (state_q == ST_IDLE) && !rst;
   assign busy       = (state_q == ST_CLEAR) || rst;
   assign cmd_accept = cmd_valid && cmd_ready;
   assign cmd_err    = cmd_err_q;
   assign cursor_col = col_q;
   assign cursor_row = row_q;
   assign pix_on     = pix_on_q;
   assign cur_addr   = AW'(int'(row_q)*COLS + int'(col_q));

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      col_d      = col_q;
      row_d      = row_q;
      cmd_err_d  = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = clr_addr_q;
      wr_data    = 8'h20;
      case (state_q)
         ST_CLEAR: begin
            wr_en = 1'b1;
            if (clr_addr_q == AW'(CELLS-1)) state_d = ST_IDLE;
            else clr_addr_d = clr_addr_q + AW'(1);
         end
         ST_IDLE: begin
            if (cmd_accept) begin
               case (cmd_op)
                  OP_PUT: begin
                     if (cmd_char != 8'h0A) begin
                        wr_en   = 1'b1;
                        wr_addr = cur_addr;
                        wr_data = cmd_char;
                     end
                     // newline behaves like a put at the last column, minus the write
                     if (cmd_char == 8'h0A || int'(col_q) == COLS-1) begin
                        col_d = '0;
                        row_d = (int'(row_q) == ROWS-1) ? '0 : row_q + RW'(1);
                     end else begin
                        col_d = col_q + CW'(1);
                     end
                  end
                  OP_SET: begin
                     if (int'(cmd_col) < COLS && int'(cmd_row) < ROWS) begin
                        col_d = cmd_col;
                        row_d = cmd_row;
                     end else begin
                        cmd_err_d = 1'b1;
                     end
                  end
                  OP_CLR: begin
                     clr_addr_d = '0;
                     col_d      = '0;
                     row_d      = '0;
                     state_d    = ST_CLEAR;
                  end
                  default: ;
               endcase
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   logic [10:0]   px, py, ox, oy, dx, dy, rx, ry;
   logic          in_win;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_char;

   // 11-bit arithmetic so a window near the 1023 edge cannot wrap
   always_comb begin
      px      = {1'b0, pixel_x};
      py      = {1'b0, pixel_y};
      ox      = {1'b0, origin_x};
      oy      = {1'b0, origin_y};
      dx      = px - ox;
      dy      = py - oy;
      in_win  = (px >= ox) && (px < ox + WIN_W) && (py >= oy) && (py < oy + WIN_H);
      rx      = dx / SCALE_W;
      ry      = dy / SCALE_W;
      rd_addr = in_win ? AW'(int'(ry)*COLS + int'(rx)) : '0;
      rd_char = ram_q[rd_addr];
      pix_on_d = in_win && (rd_char != 8'h20) && (rd_char != 8'h00);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
         col_q      <= '0;
         row_q      <= '0;
         cmd_err_q  <= 1'b0;
         pix_on_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         col_q      <= col_d;
         row_q      <= row_d;
         cmd_err_q  <= cmd_err_d;
         pix_on_q   <= pix_on_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !rst) ram_q[wr_addr] <= wr_data;
   end

endmodule

// File: tb/tb_text_cell_writer.sv
// Directed bench for text_cell_writer: boot sweep, put/set/newline/clear,
// render window edges, read-first collision and reset during a clear sweep.
module tb_text_cell_writer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b11;
   logic [7:0] cmd_char = 8'h00;
   logic [6:0] cmd_col = '0;
   logic [3:0] cmd_row = '0;
   logic       cmd_err;
   logic       busy;
   logic [6:0] cursor_col;
   logic [3:0] cursor_row;
   logic [9:0] pixel_x = '0;
   logic [9:0] pixel_y = '0;
   logic [9:0] origin_x = '0;
   logic [9:0] origin_y = '0;
   logic       pix_on;

   int n_checks = 0;
   int n_errs   = 0;

   text_cell_writer dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_char   (cmd_char),
      .cmd_col    (cmd_col),
      .cmd_row    (cmd_row),
      .cmd_err    (cmd_err),
      .busy       (busy),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .origin_x   (origin_x),
      .origin_y   (origin_y),
      .pix_on     (pix_on)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [7:0] ch,
                       input logic [6:0] col, input logic [3:0] row);
      int w = 0;
      while (!cmd_ready && w < 2000) begin
         tick;
         w++;
      end
      if (!cmd_ready) chk("send_ready_timeout", 0, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_char  = ch;
      cmd_col   = col;
      cmd_row   = row;
      tick;
      cmd_valid = 1'b0;
      cmd_op    = 2'b11;
   endtask

   task automatic expect_pix(input string tag, input int x, input int y, input int exp);
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      tick;
      chk(tag, int'(pix_on), exp);
   endtask

   task automatic wait_ready(input string tag);
      int cnt = 0;
      while (cnt < 2000) begin
         if (cmd_ready) break;
         tick;
         cnt++;
      end
      chk(tag, cnt, 800);
   endtask

   task automatic scan_window(input string tag, input int ox, input int oy);
      int lit = 0;
      origin_x = 10'(ox);
      origin_y = 10'(oy);
      for (int y = 0; y < 40; y++) begin
         for (int x = 0; x < 320; x++) begin
            pixel_x = 10'(ox + x);
            pixel_y = 10'(oy + y);
            tick;
            lit += int'(pix_on);
         end
      end
      chk(tag, lit, 0);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) tick;
      chk("rst_ready", int'(cmd_ready), 0);
      chk("rst_busy", int'(busy), 1);
      chk("rst_pix", int'(pix_on), 0);

      rst = 1'b0;
      wait_ready("boot_ready_cycle");
      chk("boot_busy", int'(busy), 0);
      chk("boot_cur_col", int'(cursor_col), 0);
      chk("boot_cur_row", int'(cursor_row), 0);
      scan_window("boot_scan_lit", 0, 0);

      origin_x = 10'd100;
      origin_y = 10'd50;
      send(2'b00, "A", 0, 0);
      chk("A_cur_col", int'(cursor_col), 1);
      chk("A_cur_row", int'(cursor_row), 0);
      expect_pix("A_lit", 101, 52, 1);
      expect_pix("A_next_cell_dark", 104, 52, 0);
      expect_pix("A_left_of_window", 99, 52, 0);

      send(2'b01, 8'h00, 79, 9);
      send(2'b00, "X", 0, 0);
      send(2'b00, "Y", 0, 0);
      chk("wrap_cur_col", int'(cursor_col), 1);
      chk("wrap_cur_row", int'(cursor_row), 0);
      expect_pix("X_at_799", 419, 89, 1);
      expect_pix("cell_798_dark", 412, 86, 0);
      expect_pix("right_edge_out", 420, 86, 0);
      expect_pix("bottom_edge_out", 416, 90, 0);
      expect_pix("Y_at_0", 100, 50, 1);

      send(2'b01, 8'h00, 3, 2);
      send(2'b00, 8'h0A, 0, 0);
      chk("nl_cur_col", int'(cursor_col), 0);
      chk("nl_cur_row", int'(cursor_row), 3);
      expect_pix("nl_no_write", 112, 58, 0);
      send(2'b01, 8'h00, 80, 0);
      chk("err_pulse", int'(cmd_err), 1);
      chk("err_cur_col", int'(cursor_col), 0);
      chk("err_cur_row", int'(cursor_row), 3);
      tick;
      chk("err_one_cycle", int'(cmd_err), 0);
      send(2'b01, 8'h00, 0, 10);
      chk("err_row_pulse", int'(cmd_err), 1);
      chk("err_row_cur_row", int'(cursor_row), 3);

      // cell (0,3) probed in the same cycle its PUT is accepted
      pixel_x   = 10'd100;
      pixel_y   = 10'd62;
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_char  = "Z";
      tick;
      cmd_valid = 1'b0;
      cmd_op    = 2'b11;
      chk("same_cycle_old", int'(pix_on), 0);
      tick;
      chk("next_cycle_new", int'(pix_on), 1);
      chk("Z_cur_col", int'(cursor_col), 1);

      send(2'b01, 8'h00, 0, 5);
      for (int i = 0; i < 5; i++) send(2'b00, "#", 0, 0);
      chk("fill_cur_col", int'(cursor_col), 5);
      expect_pix("fill_lit", 116, 70, 1);

      send(2'b10, 8'h00, 0, 0);
      chk("clr_busy", int'(busy), 1);
      chk("clr_ready", int'(cmd_ready), 0);
      chk("clr_cur_col", int'(cursor_col), 0);
      chk("clr_cur_row", int'(cursor_row), 0);
      repeat (400) tick;
      rst = 1'b1;
      tick;
      chk("midclr_rst_busy", int'(busy), 1);
      rst = 1'b0;
      wait_ready("midclr_ready_cycle");
      scan_window("after_clear_scan_lit", 100, 50);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
